// File: rtl/secuenciador_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings,
// the supported opcode set and the trap-cause codes.
package secuenciador_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_FETCH  = 3'b001;
  localparam logic [2:0] ST_DECODE = 3'b010;
  localparam logic [2:0] ST_EXEC   = 3'b011;
  localparam logic [2:0] ST_MEM    = 3'b100;
  localparam logic [2:0] ST_WB     = 3'b101;
  localparam logic [2:0] ST_TRAP   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_MEM    = ST_MEM,
    S_WB     = ST_WB,
    S_TRAP   = ST_TRAP
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'b01;
  localparam logic [1:0] CAUSE_IM_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_DM_TIMEOUT = 2'b11;

  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by the fetch and data-memory handshakes.
// o_timeout flags the last request cycle on which ready is still accepted.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_cnt;

  // Clear has priority so a fresh request always starts counting from zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_cnt <= 8'd0;
    else if (i_clr) r_cnt <= 8'd0;
    else if (i_en)  r_cnt <= r_cnt + 8'd1;
  end

  assign o_timeout = (r_cnt == LIMIT);

endmodule

// File: rtl/secuenciador_multiciclo.sv
// Multi-cycle sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback, gating the decoder's write enables and
// trapping on illegal opcodes or memory handshakes that never complete.
// Handshake: a request (im_req/dm_req) is held high every cycle in its
// state until the matching ready is seen high in the same cycle; the
// request is never withdrawn except by reset or a timeout trap.
module secuenciador_multiciclo
  import secuenciador_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 ru_we_dec,
  input  logic                 dm_wr_dec,
  input  logic                 im_ready,
  input  logic                 dm_ready,
  output logic                 im_req,
  output logic                 ir_we,
  output logic                 dm_req,
  output logic                 dm_wr,
  output logic                 ru_we,
  output logic                 pc_we,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_trap;
  logic [1:0]            r_trap_cause;
  logic [INSTRET_W-1:0]  r_instret;
  logic [1:0]            w_cause;
  logic                  w_timer_en;
  logic                  w_timer_clr;
  logic                  w_timeout;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr     (w_timer_clr),
    .i_en      (w_timer_en),
    .o_timeout (w_timeout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic, strobe decode and timer control.
  always_comb begin
    w_next     = r_state;
    w_cause    = CAUSE_NONE;
    w_timer_en = 1'b0;
    im_req     = 1'b0;
    ir_we      = 1'b0;
    dm_req     = 1'b0;
    dm_wr      = 1'b0;
    ru_we      = 1'b0;
    pc_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        im_req = 1'b1;
        ir_we  = im_ready;
        if (im_ready) begin
          w_next = S_DECODE;
        end else begin
          w_timer_en = 1'b1;
          if (w_timeout) begin
            w_next  = S_TRAP;
            w_cause = CAUSE_IM_TIMEOUT;
          end
        end
      end
      S_DECODE: begin
        if (is_legal_op(opcode)) begin
          w_next = S_EXEC;
        end else begin
          w_next  = S_TRAP;
          w_cause = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        w_next = is_mem_op(opcode) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_wr  = dm_wr_dec;
        if (dm_ready) begin
          w_next = S_WB;
        end else begin
          w_timer_en = 1'b1;
          if (w_timeout) begin
            w_next  = S_TRAP;
            w_cause = CAUSE_DM_TIMEOUT;
          end
        end
      end
      S_WB: begin
        pc_we  = 1'b1;
        ru_we  = ru_we_dec;
        w_next = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The timer restarts on every entry into a waiting state.
  assign w_timer_clr = ((w_next == S_FETCH) && (r_state != S_FETCH)) ||
                       ((w_next == S_MEM)   && (r_state != S_MEM));

  // Sticky trap capture and retired-instruction count (wraps silently).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trap       <= 1'b0;
      r_trap_cause <= CAUSE_NONE;
      r_instret    <= '0;
    end else begin
      if ((r_state != S_TRAP) && (w_next == S_TRAP)) begin
        r_trap       <= 1'b1;
        r_trap_cause <= w_cause;
      end
      if (r_state == S_WB) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  assign state      = r_state;
  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;
  assign instret    = r_instret;

endmodule
